// File: rtl/demo_pkg.sv
// Shared definitions for the two-player combat slice: player states, hit flag
// and winner encodings, box packing and combat constants.
package demo_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned BOX_W    = 4 * COORD_W;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned FLAG_W   = 2;
  localparam int unsigned WIN_W    = 2;
  localparam int unsigned HEALTH_W = 8;

  // Field offsets inside a packed {x1,x2,y1,y2} box
  localparam int unsigned BOX_X1_LSB = 3 * COORD_W;
  localparam int unsigned BOX_X2_LSB = 2 * COORD_W;
  localparam int unsigned BOX_Y1_LSB = 1 * COORD_W;
  localparam int unsigned BOX_Y2_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

  // Player FSM states
  localparam logic [STATE_W-1:0] S_IDLE           = 4'd0;
  localparam logic [STATE_W-1:0] S_MOVEFORWARDS   = 4'd1;
  localparam logic [STATE_W-1:0] S_MOVEBACKWARDS  = 4'd2;
  localparam logic [STATE_W-1:0] S_B_ATTACK_START = 4'd3;
  localparam logic [STATE_W-1:0] S_B_ATTACK_END   = 4'd4;
  localparam logic [STATE_W-1:0] S_B_ATTACK_PULL  = 4'd5;
  localparam logic [STATE_W-1:0] S_D_ATTACK_START = 4'd6;
  localparam logic [STATE_W-1:0] S_D_ATTACK_END   = 4'd7;
  localparam logic [STATE_W-1:0] S_D_ATTACK_PULL  = 4'd8;
  localparam logic [STATE_W-1:0] S_HITSTUN        = 4'd9;
  localparam logic [STATE_W-1:0] S_BLOCKSTUN      = 4'd10;

  // Hit flag encodings
  localparam logic [FLAG_W-1:0] notHit           = 2'b00;
  localparam logic [FLAG_W-1:0] hitByBasic       = 2'b01;
  localparam logic [FLAG_W-1:0] hitByDirectional = 2'b10;

  // Winner encodings
  localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
  localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
  localparam logic [WIN_W-1:0] WIN_DRAW = 2'b11;

  // Combat constants
  localparam logic [HEALTH_W-1:0] MAX_HEALTH = 8'd100;
  localparam logic [HEALTH_W-1:0] DMG_BASIC  = 8'd8;
  localparam logic [HEALTH_W-1:0] DMG_DIR    = 8'd12;
  localparam logic [HEALTH_W-1:0] DMG_CHIP   = 8'd2;
  localparam int unsigned         HITSTOP_CYCLES = 4;

  // Health subtraction clamped at zero
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    return (a > b) ? HEALTH_W'(a - b) : '0;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational normalise-and-overlap test of a hitbox against a hurtbox.
module box_overlap
  import demo_pkg::*;
(
  input  logic [BOX_W-1:0] hit_box,
  input  logic [BOX_W-1:0] hurt_box,
  output logic             overlap_c
);

  box_t a;
  box_t b;
  logic [COORD_W-1:0] a_xlo, a_xhi, a_ylo, a_yhi;
  logic [COORD_W-1:0] b_xlo, b_xhi, b_ylo, b_yhi;

  assign a = hit_box;
  assign b = hurt_box;

  // Reorder each axis to min/max, then inclusive interval overlap on both axes
  always_comb begin
    a_xlo = (a.x1 <= a.x2) ? a.x1 : a.x2;
    a_xhi = (a.x1 <= a.x2) ? a.x2 : a.x1;
    a_ylo = (a.y1 <= a.y2) ? a.y1 : a.y2;
    a_yhi = (a.y1 <= a.y2) ? a.y2 : a.y1;
    b_xlo = (b.x1 <= b.x2) ? b.x1 : b.x2;
    b_xhi = (b.x1 <= b.x2) ? b.x2 : b.x1;
    b_ylo = (b.y1 <= b.y2) ? b.y1 : b.y2;
    b_yhi = (b.y1 <= b.y2) ? b.y2 : b.y1;
    overlap_c = (a_xlo <= b_xhi) && (b_xlo <= a_xhi) &&
                (a_ylo <= b_yhi) && (b_ylo <= a_yhi);
  end

endmodule

// File: rtl/hit_arbiter.sv
// Combat referee: hit detection, trade arbitration, health and round sequencing.
// Optional feature macro: CHIP_DAMAGE_EN (blocked hits deal DMG_CHIP instead of 0).
module hit_arbiter
  import demo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                new_round,
  input  logic [STATE_W-1:0]  p1_state,
  input  logic [STATE_W-1:0]  p2_state,
  input  logic [BOX_W-1:0]    p1_basic_box,
  input  logic [BOX_W-1:0]    p2_basic_box,
  input  logic [BOX_W-1:0]    p1_dir_box,
  input  logic [BOX_W-1:0]    p2_dir_box,
  input  logic [BOX_W-1:0]    p1_hurt_box,
  input  logic [BOX_W-1:0]    p2_hurt_box,
  output logic [FLAG_W-1:0]   p1_hit_flag,
  output logic [FLAG_W-1:0]   p2_hit_flag,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                hitstop,
  output logic                round_over,
  output logic [WIN_W-1:0]    winner
);

  localparam int unsigned HS_CNT_W = $clog2(HITSTOP_CYCLES);
  localparam logic [HS_CNT_W-1:0] HS_LOAD = HS_CNT_W'(HITSTOP_CYCLES - 1);

`ifdef CHIP_DAMAGE_EN
  localparam logic [HEALTH_W-1:0] DMG_BLOCKED = DMG_CHIP;
`else
  localparam logic [HEALTH_W-1:0] DMG_BLOCKED = 8'd0;
`endif

  typedef enum logic [1:0] {FIGHT, HITSTOP, KO} arb_state_t;

  arb_state_t state_q, state_d;
  logic [HS_CNT_W-1:0] cnt_q, cnt_d;
  logic p1_used_q, p1_used_d, p2_used_q, p2_used_d;
  logic [FLAG_W-1:0]   p1_flag_d, p2_flag_d;
  logic [HEALTH_W-1:0] p1_health_d, p2_health_d;
  logic                hitstop_d, round_over_d;
  logic [WIN_W-1:0]    winner_d;

  logic ov_p1_basic, ov_p1_dir, ov_p2_basic, ov_p2_dir;
  logic p1_armed, p2_armed, p1_lands, p2_lands;
  logic [FLAG_W-1:0]   p1_atk_flag, p2_atk_flag;
  logic [HEALTH_W-1:0] p1_atk_dmg, p2_atk_dmg;

  box_overlap u_p1_basic (.hit_box(p1_basic_box), .hurt_box(p2_hurt_box), .overlap_c(ov_p1_basic));
  box_overlap u_p1_dir   (.hit_box(p1_dir_box),   .hurt_box(p2_hurt_box), .overlap_c(ov_p1_dir));
  box_overlap u_p2_basic (.hit_box(p2_basic_box), .hurt_box(p1_hurt_box), .overlap_c(ov_p2_basic));
  box_overlap u_p2_dir   (.hit_box(p2_dir_box),   .hurt_box(p1_hurt_box), .overlap_c(ov_p2_dir));

  // Per-attacker landing decision, flag type and damage dealt to the defender
  always_comb begin
    p1_armed = (p1_state == S_B_ATTACK_END) || (p1_state == S_D_ATTACK_END);
    p2_armed = (p2_state == S_B_ATTACK_END) || (p2_state == S_D_ATTACK_END);

    p1_lands = !p1_used_q &&
               !((p2_state == S_HITSTUN) || (p2_state == S_BLOCKSTUN)) &&
               (((p1_state == S_B_ATTACK_END) && ov_p1_basic) ||
                ((p1_state == S_D_ATTACK_END) && ov_p1_dir));
    p2_lands = !p2_used_q &&
               !((p1_state == S_HITSTUN) || (p1_state == S_BLOCKSTUN)) &&
               (((p2_state == S_B_ATTACK_END) && ov_p2_basic) ||
                ((p2_state == S_D_ATTACK_END) && ov_p2_dir));

    p1_atk_flag = (p1_state == S_B_ATTACK_END) ? hitByBasic : hitByDirectional;
    p2_atk_flag = (p2_state == S_B_ATTACK_END) ? hitByBasic : hitByDirectional;

    if (p2_state == S_MOVEBACKWARDS)      p1_atk_dmg = DMG_BLOCKED;
    else if (p1_state == S_B_ATTACK_END)  p1_atk_dmg = DMG_BASIC;
    else                                  p1_atk_dmg = DMG_DIR;

    if (p1_state == S_MOVEBACKWARDS)      p2_atk_dmg = DMG_BLOCKED;
    else if (p2_state == S_B_ATTACK_END)  p2_atk_dmg = DMG_BASIC;
    else                                  p2_atk_dmg = DMG_DIR;
  end

  // Round FSM next-state and next values of all registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p1_used_d    = p1_used_q;
    p2_used_d    = p2_used_q;
    p1_flag_d    = notHit;
    p2_flag_d    = notHit;
    p1_health_d  = p1_health;
    p2_health_d  = p2_health;
    hitstop_d    = 1'b0;
    round_over_d = 1'b0;
    winner_d     = winner;

    case (state_q)
      FIGHT: begin
        if (p1_lands) begin
          p2_flag_d   = p1_atk_flag;
          p2_health_d = sat_sub(p2_health, p1_atk_dmg);
          p1_used_d   = 1'b1;
        end else if (!p1_armed) begin
          p1_used_d = 1'b0;
        end
        if (p2_lands) begin
          p1_flag_d   = p2_atk_flag;
          p1_health_d = sat_sub(p1_health, p2_atk_dmg);
          p2_used_d   = 1'b1;
        end else if (!p2_armed) begin
          p2_used_d = 1'b0;
        end
        if (p1_lands || p2_lands) begin
          if ((p1_health_d == '0) || (p2_health_d == '0)) begin
            state_d      = KO;
            round_over_d = 1'b1;
            if ((p1_health_d == '0) && (p2_health_d == '0)) winner_d = WIN_DRAW;
            else if (p2_health_d == '0)                      winner_d = WIN_P1;
            else                                             winner_d = WIN_P2;
          end else begin
            state_d   = HITSTOP;
            cnt_d     = HS_LOAD;
            hitstop_d = 1'b1;
          end
        end
      end
      HITSTOP: begin
        if (cnt_q == '0) begin
          state_d = FIGHT;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          hitstop_d = 1'b1;
        end
      end
      KO: begin
        round_over_d = 1'b1;
        if (new_round) begin
          state_d      = FIGHT;
          round_over_d = 1'b0;
          p1_health_d  = MAX_HEALTH;
          p2_health_d  = MAX_HEALTH;
          p1_used_d    = 1'b0;
          p2_used_d    = 1'b0;
          winner_d     = WIN_NONE;
        end
      end
      default: state_d = FIGHT;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIGHT;
      cnt_q       <= '0;
      p1_used_q   <= 1'b0;
      p2_used_q   <= 1'b0;
      p1_hit_flag <= notHit;
      p2_hit_flag <= notHit;
      p1_health   <= MAX_HEALTH;
      p2_health   <= MAX_HEALTH;
      hitstop     <= 1'b0;
      round_over  <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_used_q   <= p1_used_d;
      p2_used_q   <= p2_used_d;
      p1_hit_flag <= p1_flag_d;
      p2_hit_flag <= p2_flag_d;
      p1_health   <= p1_health_d;
      p2_health   <= p2_health_d;
      hitstop     <= hitstop_d;
      round_over  <= round_over_d;
      winner      <= winner_d;
    end
  end

endmodule
